// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop line synchroniser, mid-bit start validation,
// centre-sampled LSB-first data, stop-bit check with one-cycle strobes.
//
// state     | meaning
// IDLE      | line idle, waiting for a low level on sync2
// START     | timing half a bit to re-check the start bit
// DATA      | sampling eight data bits at bit centres
// STOP      | sampling the stop bit; delivers byte or frame error
// WAIT_HIGH | after a framing error, waiting for the line to return high
module uart_rx #(
  parameter int CLK_FREQ = 125_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_line,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_active
);

  localparam int CPB  = CLK_FREQ / BAUD;
  localparam int HALF = (CPB - 1) / 2;
  localparam int CW   = $clog2(CPB);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);

  generate
    if (CPB < 4) begin : g_cpb_check
      $error("uart_rx: CLK_FREQ/BAUD must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t        state;
  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      sync1        <= 1'b1;
      sync2        <= 1'b1;
      cnt          <= '0;
      idx          <= '0;
      shift        <= '0;
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_active    <= 1'b0;
    end else begin
      sync1        <= rx_line;
      sync2        <= sync1;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (!sync2) begin
            state     <= START;
            rx_active <= 1'b1;
          end
        end

        START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            idx <= '0;
            if (!sync2) begin
              state <= DATA;
            end else begin
              // start bit did not survive to mid-bit: treat as a glitch
              state     <= IDLE;
              rx_active <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt        <= '0;
            shift[idx] <= sync2;
            if (idx == 3'd7) begin
              state <= STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (cnt == CNT_LAST) begin
            // leaving at mid stop bit lets a back-to-back start edge be seen
            cnt       <= '0;
            rx_active <= 1'b0;
            if (sync2) begin
              rx_data  <= shift;
              rx_valid <= 1'b1;
              state    <= IDLE;
            end else begin
              rx_frame_err <= 1'b1;
              state        <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        WAIT_HIGH: begin
          cnt <= '0;
          if (sync2) begin
            state <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          cnt       <= '0;
          rx_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver: the stage directly downstream of `uart_tx`, consuming its `tx_line` (or an external pin) and recovering 8N1 frames. Synchronises the asynchronous line, validates the start bit at mid-bit, samples eight data bits LSB-first at bit centres, and checks the stop bit. Delivers each byte as a one-cycle `rx_valid` strobe with `rx_data` held until the next good frame.

## Interface
- `CLK_FREQ`, 125_000_000, system clock frequency in Hz
- `BAUD`, 115200, line bit rate; `CPB = CLK_FREQ / BAUD` (integer divide, 1085 by default), `HALF = (CPB-1)/2` (542); `CPB >= 4` required, elaboration error otherwise
- `clk`  in  1  system clock; all logic on the rising edge
- `rst`  in  1  reset, synchronous, active-low
- `rx_line`  in  1  asynchronous serial input, idle high
- `rx_data`  out  8  last correctly received byte
- `rx_valid`  out  1  one-cycle strobe: new byte on `rx_data`
- `rx_frame_err`  out  1  one-cycle strobe: stop bit sampled low
- `rx_active`  out  1  high while a frame is being received

## Operation
- Two-flop synchroniser on `rx_line` (`sync1`, `sync2`), both reset to 1. All decisions use `sync2` only.
- Bit counter width `$clog2(CPB)`; bit index 3 bits; shift register 8 bits.
- States:
  - IDLE: counter 0. `sync2 == 0` -> START.
  - START: count up. At `cnt == HALF`, sample: 0 -> DATA, counter 0, index 0. 1 -> IDLE (glitch rejected, no strobe).
  - DATA: count up. At `cnt == CPB-1`, sample `sync2` into `shift[index]` (LSB first), counter 0. Index 7 -> STOP, else index+1.
  - STOP: at `cnt == CPB-1`, sample. 1 -> `rx_data <= shift`, `rx_valid` pulse, IDLE. 0 -> `rx_frame_err` pulse, `rx_data` unchanged, WAIT_HIGH.
  - WAIT_HIGH: stay until `sync2 == 1`, then IDLE. A held-low line (break) yields exactly one frame error.
- `rx_active` = state in {START, DATA, STOP}. It is low in IDLE and WAIT_HIGH.
- `rx_valid` and `rx_frame_err` are never high in the same cycle.
- Neither strobe lasts more than one cycle.
- No input handshake. The consumer must take `rx_data` on `rx_valid`. The byte is held until the next good frame overwrites it.
- Reset (`rst == 0` at a clock edge), including mid-frame:
  - state IDLE, counters 0
  - `rx_data = 8'h00`, `rx_valid = 0`, `rx_frame_err = 0`, `rx_active = 0`
  - synchronisers = 1
  - The aborted frame produces no strobe. Reception resumes at the next falling edge seen after reset release.

## Timing
- E0 = first clock edge sampling `rx_line` low. `sync2` goes low at E0+2, and START is entered then.
- Start-bit sample at E0+2+HALF.
- Data bit k (0..7) sampled at E0+2+HALF+(k+1)*CPB.
- Stop bit sampled at E0+2+HALF+9*CPB.
- `rx_valid` / `rx_frame_err` high for the single cycle after the stop sample.
- `rx_active` rises at E0+3 and falls together with the strobe.
- Bench tolerance: ±1 cycle on all of the above.
- Back-to-back frames: the receiver is back in IDLE about half a bit before the stop bit ends. A start edge immediately after the stop bit is caught with no lost frame.
- Tolerates ±2% baud mismatch between sender and receiver with no bit error.

## Test plan
- Use `CLK_FREQ=1_000_000`, `BAUD=100_000` (CPB=10, HALF=4) for speed, plus one run at defaults.
- Loopback from `uart_tx` sending 8'h6B -> exactly one `rx_valid` with `rx_data == 8'h6B`. `rx_active` high for about 9.5 bit times. No `rx_frame_err`.
- Back-to-back "katia" (6B 61 74 69 61) with zero idle gap -> five `rx_valid` strobes, in order, with matching bytes. No errors.
- Low glitch of HALF-1 cycles on an idle line -> START entered and then abandoned. No strobe. Back in IDLE within HALF+3 cycles.
- Frame 8'h55 with stop bit driven low, then line held low 3*CPB, then high -> one `rx_frame_err`. `rx_data` keeps the previous byte. No further activity until the line goes high. The next good frame of 8'hA5 is received correctly.
- Assert `rst` low for 2 cycles during data bit 4 -> all outputs at reset values. No strobe for the aborted frame. The following frame of 8'h3C is received correctly.
- Baud skew: sender at CPB=10 vs receiver at CPB=10 with the sender ±2% -> 16 random bytes all received correctly.
